// File: rtl/two24_acc_dump_pkg.sv
// two24_pkg: shared lane width, saturation limits, lane type and the
// accumulator state encoding for the dual 24-bit lane accumulator.
package two24_pkg;

  localparam int LANE_W = 24;
  localparam int NLANES = 2;

  localparam logic [LANE_W-1:0] SAT_MAX = 24'h7FFFFF;
  localparam logic [LANE_W-1:0] SAT_MIN = 24'h800000;

  typedef logic signed [LANE_W-1:0] lane_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/two24_acc_dump_sat_add.sv
// two24_sat_add: combinational single-lane signed 24-bit add.
// Build macro: TWO24_ACC_DUMP_SAT_EN
//   defined   -> result clamps to SAT_MAX / SAT_MIN on overflow, ovf_o flags it
//   undefined -> result wraps modulo 2^24, ovf_o is always 0
// Ports:
//   a_i, b_i : signed lane operands
//   sum_o    : lane result
//   ovf_o    : overflow occurred (saturating build only)
module two24_sat_add
  import two24_pkg::*;
(
  input  lane_t a_i,
  input  lane_t b_i,
  output lane_t sum_o,
  output logic  ovf_o
);

  lane_t raw_s;

  // Lane add with optional clamping on signed overflow.
  always_comb begin
    raw_s = a_i + b_i;
`ifdef TWO24_ACC_DUMP_SAT_EN
    // Overflow only when both operands share a sign the result does not.
    ovf_o = (a_i[LANE_W-1] == b_i[LANE_W-1]) && (raw_s[LANE_W-1] != a_i[LANE_W-1]);
    if (ovf_o) begin
      sum_o = a_i[LANE_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_o = raw_s;
    end
`else
    ovf_o = 1'b0;
    sum_o = raw_s;
`endif
  end

endmodule

// File: rtl/two24_acc_dump.sv
// two24_acc_dump: accumulates the two signed 24-bit lanes of a 48-bit DSP
// P word over a frame of len+1 samples and dumps both totals through a
// one-deep valid/ready output register.
// Build macro: TWO24_ACC_DUMP_SAT_EN enables per-lane saturation and sat_o.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   len_i            : frame length minus one, sampled at frame start
//   dat_i, valid_i   : input lanes {lane1, lane0} and their valid
//   ready_o          : input can be accepted (low while a dump is pending)
//   dat_o, sat_o     : dumped lane totals and per-lane saturation flags
//   valid_o, ready_i : output handshake
module two24_acc_dump
  import two24_pkg::*;
#(
  parameter int LEN_BITS = 8,
  parameter int LANE_W   = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [LEN_BITS-1:0]   len_i,
  input  logic [2*LANE_W-1:0]   dat_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [2*LANE_W-1:0]   dat_o,
  output logic [NLANES-1:0]     sat_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  acc_state_t                       state_q, state_d;
  logic [NLANES-1:0][LANE_W-1:0]    acc_q, acc_d;
  logic [LEN_BITS-1:0]              cnt_q, cnt_d;
  logic [LEN_BITS-1:0]              len_q, len_d;
  logic [2*LANE_W-1:0]              dat_q, dat_d;
  logic                             valid_q, valid_d;
  logic                             ready_q, ready_d;

  logic [NLANES-1:0][LANE_W-1:0]    opa_s;
  logic [NLANES-1:0][LANE_W-1:0]    sum_s;
  logic [NLANES-1:0]                ovf_s;
  logic                             first_s;
  logic                             last_s;
  logic                             accept_s;
  logic                             out_free_s;
  logic [LEN_BITS-1:0]              eff_len_s;

`ifdef TWO24_ACC_DUMP_SAT_EN
  logic [NLANES-1:0]                sat_q, sat_d;
  logic [NLANES-1:0]                sato_q, sato_d;
  logic [NLANES-1:0]                stick_s;
`else
  logic                             ovf_unused_s;
  assign ovf_unused_s = |ovf_s;
`endif

  // A new frame starts from zero, so the first sample ignores the old acc.
  assign first_s    = (cnt_q == {LEN_BITS{1'b0}});
  assign eff_len_s  = first_s ? len_i : len_q;
  assign accept_s   = valid_i && (state_q == ACCUM);
  assign last_s     = (cnt_q == eff_len_s);
  assign out_free_s = !valid_q || ready_i;
  assign opa_s      = first_s ? {(NLANES*LANE_W){1'b0}} : acc_q;

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    two24_sat_add u_add (
      .a_i   (opa_s[l]),
      .b_i   (dat_i[l*LANE_W +: LANE_W]),
      .sum_o (sum_s[l]),
      .ovf_o (ovf_s[l])
    );
  end

`ifdef TWO24_ACC_DUMP_SAT_EN
  assign stick_s = (first_s ? {NLANES{1'b0}} : sat_q) | ovf_s;
`endif

  // Next-state logic for accumulation, frame end and the output register.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    dat_d   = dat_q;
    // A completed handshake empties the output unless a dump reloads it below.
    valid_d = valid_q && !ready_i;
`ifdef TWO24_ACC_DUMP_SAT_EN
    sat_d   = sat_q;
    sato_d  = sato_q;
`endif
    case (state_q)
      ACCUM: begin
        if (accept_s) begin
          if (first_s) begin
            len_d = len_i;
          end else begin
            len_d = len_q;
          end
          if (last_s) begin
            if (out_free_s) begin
              dat_d   = sum_s;
              valid_d = 1'b1;
              acc_d   = {(NLANES*LANE_W){1'b0}};
              cnt_d   = {LEN_BITS{1'b0}};
`ifdef TWO24_ACC_DUMP_SAT_EN
              sato_d  = stick_s;
              sat_d   = {NLANES{1'b0}};
`endif
            end else begin
              // Output still occupied: park the totals in acc until it frees.
              acc_d   = sum_s;
              state_d = HOLD;
`ifdef TWO24_ACC_DUMP_SAT_EN
              sat_d   = stick_s;
`endif
            end
          end else begin
            acc_d = sum_s;
            cnt_d = cnt_q + LEN_BITS'(1);
`ifdef TWO24_ACC_DUMP_SAT_EN
            sat_d = stick_s;
`endif
          end
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (out_free_s) begin
          dat_d   = acc_q;
          valid_d = 1'b1;
          acc_d   = {(NLANES*LANE_W){1'b0}};
          cnt_d   = {LEN_BITS{1'b0}};
          state_d = ACCUM;
`ifdef TWO24_ACC_DUMP_SAT_EN
          sato_d  = sat_q;
          sat_d   = {NLANES{1'b0}};
`endif
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACCUM;
        acc_d   = {(NLANES*LANE_W){1'b0}};
        cnt_d   = {LEN_BITS{1'b0}};
      end
    endcase
    // ready_o mirrors the next state so it is a plain flop output.
    ready_d = (state_d == ACCUM);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACCUM;
      acc_q   <= {(NLANES*LANE_W){1'b0}};
      cnt_q   <= {LEN_BITS{1'b0}};
      len_q   <= {LEN_BITS{1'b0}};
      dat_q   <= {(2*LANE_W){1'b0}};
      valid_q <= 1'b0;
      ready_q <= 1'b1;
`ifdef TWO24_ACC_DUMP_SAT_EN
      sat_q   <= {NLANES{1'b0}};
      sato_q  <= {NLANES{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dat_q   <= dat_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
`ifdef TWO24_ACC_DUMP_SAT_EN
      sat_q   <= sat_d;
      sato_q  <= sato_d;
`endif
    end
  end

  assign dat_o   = dat_q;
  assign valid_o = valid_q;
  assign ready_o = ready_q;
`ifdef TWO24_ACC_DUMP_SAT_EN
  assign sat_o   = sato_q;
`else
  assign sat_o   = 2'b00;
`endif

endmodule

// File: tb/tb_two24_acc_dump.sv
// Testbench for two24_acc_dump: directed scenarios followed by random
// traffic, all dumps checked against a frame-level arithmetic model.
module tb_two24_acc_dump;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  len_i;
  logic [47:0] dat_i;
  logic        valid_i;
  logic        ready_o;
  logic [47:0] dat_o;
  logic [1:0]  sat_o;
  logic        valid_o;
  logic        ready_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] d;
    logic [1:0]  s;
  } dump_t;

  dump_t  exp_q[$];
  longint m_s0, m_s1;
  bit     m_f0, m_f1;
  int     m_cnt = 0;
  int     m_len = 0;

  logic [47:0] a_v, b_v;

  always #5 clk_i = ~clk_i;

  two24_acc_dump dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .len_i   (len_i),
    .dat_i   (dat_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .dat_o   (dat_o),
    .sat_o   (sat_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Running lane sum; the saturating build clamps after every sample.
  function automatic longint lane_add(input longint a, input longint b, inout bit f);
    longint r;
    r = a + b;
`ifdef TWO24_ACC_DUMP_SAT_EN
    if (r > 64'sd8388607) begin
      r = 64'sd8388607;
      f = 1'b1;
    end else if (r < -64'sd8388608) begin
      r = -64'sd8388608;
      f = 1'b1;
    end
`endif
    return r;
  endfunction

  task automatic model_accept(input logic [47:0] d, input logic [7:0] len);
    dump_t e;
    if (m_cnt == 0) begin
      m_len = int'(len);
      m_s0 = 0; m_s1 = 0; m_f0 = 1'b0; m_f1 = 1'b0;
    end
    m_s0 = lane_add(m_s0, longint'($signed(d[23:0])), m_f0);
    m_s1 = lane_add(m_s1, longint'($signed(d[47:24])), m_f1);
    m_cnt++;
    if (m_cnt == m_len + 1) begin
      e.d = {m_s1[23:0], m_s0[23:0]};
      e.s = {m_f1, m_f0};
      exp_q.push_back(e);
      m_cnt = 0;
    end
  endtask

  // One clock: score the output handshake, advance, then update the model.
  task automatic step();
    bit          acc, hs;
    logic [47:0] d;
    logic [7:0]  l;
    dump_t       e;
    acc = !rst_i && valid_i && ready_o;
    hs  = !rst_i && valid_o && ready_i;
    d   = dat_i;
    l   = len_i;
    if (hs) begin
      chk("sb_dump_expected", 48'(exp_q.size() != 0), 48'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_dat", dat_o, e.d);
        chk("sb_sat", {46'd0, sat_o}, {46'd0, e.s});
      end
    end
    @(posedge clk_i);
    #1;
    if (rst_i) begin
      exp_q.delete();
      m_cnt = 0;
    end else if (acc) begin
      model_accept(d, l);
    end
  endtask

  task automatic send(input logic [23:0] l1, input logic [23:0] l0);
    dat_i   = {l1, l0};
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  function automatic logic [23:0] rnd_lane();
    logic [23:0] v;
    if ($urandom_range(0, 3) == 0) begin
      v = 24'($urandom);
    end else begin
      v = 24'(int'($urandom_range(0, 200)) - 100);
    end
    return v;
  endfunction

  initial begin
    rst_i = 1'b1; len_i = 8'd0; dat_i = 48'd0; valid_i = 1'b0; ready_i = 1'b1;
    step();
    chk("rst_valid", 48'(valid_o), 48'd0);
    chk("rst_ready", 48'(ready_o), 48'd1);
    chk("rst_dat",   dat_o, 48'd0);
    chk("rst_sat",   48'(sat_o), 48'd0);
    rst_i = 1'b0;
    step();
    chk("post_rst_ready", 48'(ready_o), 48'd1);

    // Frame sum over four samples.
    len_i = 8'd3;
    send(24'd1, 24'd10);
    send(24'd2, 24'd20);
    send(24'd3, 24'd30);
    chk("sum_not_early", 48'(valid_o), 48'd0);
    send(24'd4, 24'd40);
    chk("sum_valid", 48'(valid_o), 48'd1);
    chk("sum_dat", dat_o, {24'd10, 24'd100});
    chk("sum_sat", 48'(sat_o), 48'd0);
    step(); step();

    // Positive overflow on lane0, lane1 negative but in range.
    len_i = 8'd1;
    send(24'hFFFFFB, 24'h600000);
    send(24'hFFFFFB, 24'h600000);
`ifdef TWO24_ACC_DUMP_SAT_EN
    chk("pos_dat", dat_o, {24'hFFFFF6, 24'h7FFFFF});
    chk("pos_sat", 48'(sat_o), 48'd1);
`else
    chk("pos_dat", dat_o, {24'hFFFFF6, 24'hC00000});
    chk("pos_sat", 48'(sat_o), 48'd0);
`endif
    step(); step();

    // Negative overflow on lane1, then a clean frame must clear the flag.
    send(24'h900000, 24'd0);
    send(24'h900000, 24'd0);
`ifdef TWO24_ACC_DUMP_SAT_EN
    chk("neg_dat", dat_o, {24'h800000, 24'd0});
    chk("neg_sat", 48'(sat_o), 48'd2);
`else
    chk("neg_dat", dat_o, {24'h200000, 24'd0});
    chk("neg_sat", 48'(sat_o), 48'd0);
`endif
    send(24'd1, 24'd2);
    send(24'd3, 24'd4);
    chk("clean_dat", dat_o, {24'd4, 24'd6});
    chk("clean_sat", 48'(sat_o), 48'd0);
    step(); step();

    // Backpressure with single-sample frames.
    len_i = 8'd0; ready_i = 1'b0; valid_i = 1'b1;
    a_v = {rnd_lane(), rnd_lane()};
    dat_i = a_v;
    step();
    chk("bp_first_valid", 48'(valid_o), 48'd1);
    chk("bp_first_dat", dat_o, a_v);
    b_v = {rnd_lane(), rnd_lane()};
    dat_i = b_v;
    step();
    chk("bp_hold_ready", 48'(ready_o), 48'd0);
    chk("bp_hold_dat", dat_o, a_v);
    for (int i = 0; i < 3; i++) begin
      dat_i = {rnd_lane(), rnd_lane()};
      step();
      chk("bp_hold_ready", 48'(ready_o), 48'd0);
      chk("bp_stable_dat", dat_o, a_v);
    end
    ready_i = 1'b1;
    dat_i = {rnd_lane(), rnd_lane()};
    step();
    chk("bp_second_dat", dat_o, b_v);
    chk("bp_second_valid", 48'(valid_o), 48'd1);
    for (int i = 0; i < 4; i++) begin
      dat_i = {rnd_lane(), rnd_lane()};
      step();
    end
    valid_i = 1'b0;
    step(); step(); step();

    // Reset in the middle of a frame discards everything.
    len_i = 8'd7;
    for (int i = 0; i < 4; i++) send(rnd_lane(), rnd_lane());
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("mid_rst_valid", 48'(valid_o), 48'd0);
    chk("mid_rst_ready", 48'(ready_o), 48'd1);
    step();
    chk("mid_rst_idle", 48'(valid_o), 48'd0);
    for (int i = 1; i <= 8; i++) begin
      send(24'(i), 24'(2 * i));
      if (i < 8) chk("post_rst_no_dump", 48'(valid_o), 48'd0);
    end
    chk("post_rst_dat", dat_o, {24'd36, 24'd72});
    step(); step();

    // Length change mid-frame takes effect only at the next frame.
    len_i = 8'd2;
    send(24'd0, 24'd5);
    len_i = 8'd0;
    send(24'd0, 24'd6);
    chk("len_chg_no_dump", 48'(valid_o), 48'd0);
    send(24'd0, 24'd7);
    chk("len_chg_dat", dat_o, {24'd0, 24'd18});
    send(24'd0, 24'd9);
    chk("len0_dat_a", dat_o, {24'd0, 24'd9});
    send(24'd0, 24'd11);
    chk("len0_dat_b", dat_o, {24'd0, 24'd11});
    step(); step();

    // Random traffic with random handshakes and a wandering len_i.
    for (int i = 0; i < 600; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      len_i   = 8'($urandom_range(0, 4));
      dat_i   = {rnd_lane(), rnd_lane()};
      step();
    end

    // Finish any open frame deterministically, then drain.
    len_i = 8'd0; ready_i = 1'b1; valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dat_i = {rnd_lane(), rnd_lane()};
      step();
    end
    valid_i = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("drain_empty", 48'(exp_q.size()), 48'd0);
    chk("drain_valid", 48'(valid_o), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
